// File: rtl/arm_pkg.sv
// Shared decode definitions: instruction field positions, TypeCode classes
// and the decoded-instruction record produced by the decoder.
package arm_pkg;

    localparam int TYPE_MSB     = 31;
    localparam int TYPE_LSB     = 30;
    localparam int OP_MSB       = 29;
    localparam int OP_LSB       = 26;
    localparam int IMM_FLAG_BIT = 25;
    localparam int RD_MSB       = 24;
    localparam int RD_LSB       = 21;
    localparam int RH_MSB       = 20;
    localparam int RH_LSB       = 17;
    localparam int RO_MSB       = 16;
    localparam int RO_LSB       = 13;
    localparam int IMM_MSB      = 16;
    localparam int NUM_REGS     = 16;

    localparam logic [1:0] TYPE_CMP   = 2'b01;
    localparam logic [1:0] TYPE_EXT   = 2'b11;
    localparam logic [3:0] OP_ILLEGAL = 4'hF;

    typedef struct packed {
        logic [3:0]  op_code;
        logic [1:0]  type_code;
        logic        is_imm;
        logic [31:0] imm_value;
        logic [3:0]  rd;
        logic [3:0]  rh;
        logic [3:0]  ro;
        logic        writes_rd;
        logic        illegal;
    } dec_instr_t;

    function automatic dec_instr_t decode_instr(input logic [31:0] raw);
        dec_instr_t d;
        d.type_code = raw[TYPE_MSB:TYPE_LSB];
        d.op_code   = raw[OP_MSB:OP_LSB];
        d.is_imm    = raw[IMM_FLAG_BIT];
        d.rd        = raw[RD_MSB:RD_LSB];
        d.rh        = raw[RH_MSB:RH_LSB];
        d.ro        = raw[RO_MSB:RO_LSB];
        d.imm_value = d.is_imm ? {{(31 - IMM_MSB){raw[IMM_MSB]}}, raw[IMM_MSB:0]} : 32'd0;
        d.illegal   = (d.type_code == TYPE_EXT) && (d.op_code == OP_ILLEGAL);
        // Compare-class and illegal encodings never produce a destination write.
        d.writes_rd = (d.type_code != TYPE_CMP) && !d.illegal;
        return d;
    endfunction

endpackage

// File: rtl/dec_scoreboard.sv
// Pending-write mask for the decoder: a reader stalls while any source it
// uses is still waiting for writeback. No bypass of same-cycle retires.
module dec_scoreboard
    import arm_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       set_en,
    input  logic [3:0] set_addr,
    input  logic       clr_en,
    input  logic [3:0] clr_addr,
    input  logic [3:0] rh_addr,
    input  logic [3:0] ro_addr,
    input  logic       is_imm,
    output logic       stall
);

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;

    // The set is applied after the clear so a new writer wins over a retire.
    always_comb begin
        pending_d = pending_q;
        if (clr_en) pending_d[clr_addr] = 1'b0;
        if (set_en) pending_d[set_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pending_q <= '0;
        else          pending_q <= pending_d;
    end

    assign stall = pending_q[rh_addr] || (!is_imm && pending_q[ro_addr]);

endmodule

// File: rtl/instr_decoder.sv
// Single-stage instruction decoder with valid/ready handshake and flush.
// Hazard scoreboard is included only when DECODER_SCOREBOARD_EN is defined.
module instr_decoder
    import arm_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  OpCode,
    output logic [1:0]  TypeCode,
    output logic        is_immediate,
    output logic [31:0] immediate_value,
    output logic [3:0]  rd_addr,
    output logic [3:0]  rh_addr,
    output logic [3:0]  ro_addr,
    output logic        writes_rd,
    output logic        illegal,
    input  logic        wb_valid,
    input  logic [3:0]  wb_rd
);

    dec_instr_t in_dec;
    dec_instr_t dec_q;
    dec_instr_t dec_d;
    logic       out_valid_q;
    logic       out_valid_d;
    logic       stall;
    logic       accept;

    assign in_dec = decode_instr(instr);

`ifdef DECODER_SCOREBOARD_EN
    dec_scoreboard u_scoreboard (
        .clk      (clk),
        .reset_n  (reset_n),
        .set_en   (accept && in_dec.writes_rd),
        .set_addr (in_dec.rd),
        .clr_en   (wb_valid),
        .clr_addr (wb_rd),
        .rh_addr  (in_dec.rh),
        .ro_addr  (in_dec.ro),
        .is_imm   (in_dec.is_imm),
        .stall    (stall)
    );
`else
    logic unused_wb;
    assign unused_wb = ^{wb_valid, wb_rd};
    assign stall     = 1'b0;
`endif

    // Gating with reset_n keeps the input side closed for the whole reset.
    assign in_ready = reset_n && (!out_valid_q || out_ready) && !stall && !flush;
    assign accept   = in_valid && in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        dec_d       = dec_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            dec_d       = in_dec;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            dec_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            dec_q       <= dec_d;
        end
    end

    assign out_valid       = out_valid_q;
    assign OpCode          = dec_q.op_code;
    assign TypeCode        = dec_q.type_code;
    assign is_immediate    = dec_q.is_imm;
    assign immediate_value = dec_q.imm_value;
    assign rd_addr         = dec_q.rd;
    assign rh_addr         = dec_q.rh;
    assign ro_addr         = dec_q.ro;
    assign writes_rd       = dec_q.writes_rd;
    assign illegal         = dec_q.illegal;

endmodule

// File: tb/tb_instr_decoder.sv
// Scoreboard bench for instr_decoder: the driver queues hand-computed decodes,
// a monitor pops and compares them on every output handshake.
module tb_instr_decoder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  OpCode;
    logic [1:0]  TypeCode;
    logic        is_immediate;
    logic [31:0] immediate_value;
    logic [3:0]  rd_addr;
    logic [3:0]  rh_addr;
    logic [3:0]  ro_addr;
    logic        writes_rd;
    logic        illegal;
    logic        wb_valid;
    logic [3:0]  wb_rd;

    typedef struct packed {
        logic [3:0]  op;
        logic [1:0]  typ;
        logic        imm;
        logic [31:0] immv;
        logic [3:0]  rd;
        logic [3:0]  rh;
        logic [3:0]  ro;
        logic        wr;
        logic        ill;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    instr_decoder dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .instr           (instr),
        .flush           (flush),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .OpCode          (OpCode),
        .TypeCode        (TypeCode),
        .is_immediate    (is_immediate),
        .immediate_value (immediate_value),
        .rd_addr         (rd_addr),
        .rh_addr         (rh_addr),
        .ro_addr         (ro_addr),
        .writes_rd       (writes_rd),
        .illegal         (illegal),
        .wb_valid        (wb_valid),
        .wb_rd           (wb_rd)
    );

    always #5 clk = ~clk;

    function automatic exp_t currentOut();
        exp_t a;
        a = {OpCode, TypeCode, is_immediate, immediate_value,
             rd_addr, rh_addr, ro_addr, writes_rd, illegal};
        return a;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Presents one instruction and expects acceptance after expWait stalled cycles.
    task automatic applyStimulus(input logic [31:0] ins, input exp_t e, input int expWait);
        int waited = 0;
        bit done = 0;
        instr    = ins;
        in_valid = 1'b1;
        while (!done && waited < 50) begin
            @(negedge clk);
            if (in_ready) begin
                expQ.push_back(e);
                done = 1;
            end else begin
                waited++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            checkOutput("acceptTimeout", 64'd0, 64'd1);
        end else begin
            checkOutput("acceptWait", 64'(waited), 64'(expWait));
            checkOutput("latency", 64'(out_valid), 64'd1);
        end
    endtask

    task automatic wbRetire(input logic [3:0] r);
        wb_valid = 1'b1;
        wb_rd    = r;
        @(posedge clk);
        #1;
        wb_valid = 1'b0;
    endtask

    // Reader blocked on register r: held two cycles, then released by writeback.
    task automatic stalledAccept(input logic [31:0] ins, input exp_t e, input logic [3:0] r);
`ifdef DECODER_SCOREBOARD_EN
        instr    = ins;
        in_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checkOutput("stallHold", 64'(in_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        wb_valid = 1'b1;
        wb_rd    = r;
        @(negedge clk);
        checkOutput("noBypass", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        wb_valid = 1'b0;
        @(negedge clk);
        checkOutput("releaseAfterWb", 64'(in_ready), 64'd1);
        if (in_ready) expQ.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("latency", 64'(out_valid), 64'd1);
`else
        applyStimulus(ins, e, 0);
        wbRetire(r);
`endif
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedOutput", 64'd1, 64'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("decodedOutput", 64'(currentOut()), 64'(e));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] iA, iB, iR2;
        exp_t eA, eB, eR2;
        iA  = {2'b10, 4'h3, 1'b0, 4'd5, 4'd6, 4'd7, 13'h0};
        eA  = '{4'h3, 2'd2, 1'b0, 32'h0, 4'd5, 4'd6, 4'd7, 1'b1, 1'b0};
        iB  = {2'b00, 4'h9, 1'b1, 4'd8, 4'd2, 17'h01234};
        eB  = '{4'h9, 2'd0, 1'b1, 32'h00001234, 4'd8, 4'd2, 4'd0, 1'b1, 1'b0};
        iR2 = {2'b01, 4'h6, 1'b0, 4'd7, 4'd6, 4'd6, 13'h0};
        eR2 = '{4'h6, 2'd1, 1'b0, 32'h0, 4'd7, 4'd6, 4'd6, 1'b0, 1'b0};

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        instr     = 32'h0;
        flush     = 1'b0;
        out_ready = 1'b1;
        wb_valid  = 1'b0;
        wb_rd     = 4'd0;
        #2;
        checkOutput("resetInReady", 64'(in_ready), 64'd0);
        checkOutput("resetOutValid", 64'(out_valid), 64'd0);
        checkOutput("resetDecoded", 64'(currentOut()), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("readyAfterReset", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        $display("[TB] basic decode with negative immediate");
        applyStimulus(32'h1263FFFF,
                      '{4'h4, 2'd0, 1'b1, 32'hFFFFFFFF, 4'd3, 4'd1, 4'hF, 1'b1, 1'b0}, 0);
        wbRetire(4'd3);

        $display("[TB] output backpressure");
        out_ready = 1'b0;
        applyStimulus(iA, eA, 0);
        fork
            applyStimulus(iB, eB, 3);
            begin
                repeat (3) begin
                    @(negedge clk);
                    checkOutput("bpInReady", 64'(in_ready), 64'd0);
                    checkOutput("bpHeld", 64'(currentOut()), 64'(eA));
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        wbRetire(4'd5);
        wbRetire(4'd8);

        $display("[TB] read-after-write hazard on r3");
        applyStimulus({2'b00, 4'h1, 1'b1, 4'd3, 4'd0, 17'h0},
                      '{4'h1, 2'd0, 1'b1, 32'h0, 4'd3, 4'd0, 4'd0, 1'b1, 1'b0}, 0);
        stalledAccept({2'b01, 4'h2, 1'b1, 4'd4, 4'd3, 17'h1FFFF},
                      '{4'h2, 2'd1, 1'b1, 32'hFFFFFFFF, 4'd4, 4'd3, 4'hF, 1'b0, 1'b0}, 4'd3);

        $display("[TB] same-cycle set and clear of r5");
        wb_valid = 1'b1;
        wb_rd    = 4'd5;
        applyStimulus({2'b10, 4'h7, 1'b0, 4'd5, 4'd1, 4'd2, 13'h1FFF},
                      '{4'h7, 2'd2, 1'b0, 32'h0, 4'd5, 4'd1, 4'd2, 1'b1, 1'b0}, 0);
        wb_valid = 1'b0;
        stalledAccept({2'b01, 4'h0, 1'b1, 4'd0, 4'd5, 17'h00010},
                      '{4'h0, 2'd1, 1'b1, 32'h00000010, 4'd0, 4'd5, 4'd0, 1'b0, 1'b0}, 4'd5);

        $display("[TB] illegal encoding and flush");
        applyStimulus({2'b11, 4'hF, 1'b0, 4'd9, 4'd1, 4'd2, 13'h0},
                      '{4'hF, 2'd3, 1'b0, 32'h0, 4'd9, 4'd1, 4'd2, 1'b0, 1'b1}, 0);
        applyStimulus({2'b00, 4'h2, 1'b1, 4'd1, 4'd9, 17'h10000},
                      '{4'h2, 2'd0, 1'b1, 32'hFFFF0000, 4'd1, 4'd9, 4'd8, 1'b1, 1'b0}, 0);
        wbRetire(4'd1);
        out_ready = 1'b0;
        applyStimulus({2'b01, 4'h4, 1'b0, 4'd10, 4'd11, 4'd12, 13'h0},
                      '{4'h4, 2'd1, 1'b0, 32'h0, 4'd10, 4'd11, 4'd12, 1'b0, 1'b0}, 0);
        flush = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("flushClears", 64'(out_valid), 64'd0);
        void'(expQ.pop_back());
        in_valid = 1'b1;
        instr    = iA;
        @(negedge clk);
        checkOutput("flushBlocksAccept", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        checkOutput("flushNoAccept", 64'(out_valid), 64'd0);
        out_ready = 1'b1;

        $display("[TB] reset during a stall");
        applyStimulus({2'b00, 4'h5, 1'b1, 4'd6, 4'd0, 17'h0},
                      '{4'h5, 2'd0, 1'b1, 32'h0, 4'd6, 4'd0, 4'd0, 1'b1, 1'b0}, 0);
        instr    = iR2;
        in_valid = 1'b1;
        @(negedge clk);
`ifdef DECODER_SCOREBOARD_EN
        checkOutput("stallBeforeReset", 64'(in_ready), 64'd0);
`else
        checkOutput("noStallBeforeReset", 64'(in_ready), 64'd1);
`endif
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("midResetOutValid", 64'(out_valid), 64'd0);
        checkOutput("midResetInReady", 64'(in_ready), 64'd0);
        checkOutput("midResetDecoded", 64'(currentOut()), 64'd0);
        expQ.delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("readyAfterRelease", 64'(in_ready), 64'd1);
        if (in_ready) expQ.push_back(eR2);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("latency", 64'(out_valid), 64'd1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("queueDrained", 64'(expQ.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_decoder.md
INSTR_DECODER -- requirements
Module: instr_decoder

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: reset_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: in_valid  in  1; in_ready  out  1; instr  in  32  raw instruction word.
REQ-004 SHALL have ports: flush  in  1  discards the held instruction.
REQ-005 SHALL have ports: out_valid  out  1; out_ready  in  1.
REQ-006 SHALL have ports: OpCode  out  4; TypeCode  out  2; is_immediate  out  1; immediate_value  out  32.
REQ-007 SHALL have ports: rd_addr, rh_addr, ro_addr  out  4 each; writes_rd  out  1; illegal  out  1.
REQ-008 SHALL have ports: wb_valid  in  1; wb_rd  in  4  writeback retire, which clears the pending state of wb_rd.

Function
REQ-009 SHALL decode the instruction fields as follows: TypeCode=instr[31:30], OpCode=instr[29:26], is_immediate=instr[25], rd=[24:21], rh=[20:17], ro=[16:13], imm17=[16:0].
REQ-010 SHALL set immediate_value to imm17 sign-extended to 32 bits when is_immediate=1, and to 0 otherwise.
REQ-011 SHALL set writes_rd=0 for TypeCode 2'b01 (compare class) and writes_rd=1 otherwise.
REQ-012 SHALL set illegal=1 for TypeCode=2'b11 with OpCode=4'hF, and SHALL force writes_rd=0 for that encoding.
REQ-013 SHALL be a single output register stage with latency 1: an instruction accepted at edge N has out_valid=1 after edge N.
REQ-014 SHALL assert in_ready = (!out_valid || out_ready) && !stall && !flush.
REQ-015 SHALL accept an instruction only when in_valid && in_ready; otherwise, if out_ready=1, out_valid clears at the next edge.
REQ-016 SHALL hold all outputs stable while out_valid && !out_ready.
REQ-017 SHALL make flush clear out_valid at the next edge, override acceptance, and leave scoreboard entries of flushed instructions set.
REQ-018 SHALL have a stall condition: stall=1 when pending[rh] is set, or when !is_immediate and pending[ro] is set, evaluated on the registered mask with no bypass.
REQ-019 SHALL set pending[rd] on acceptance when writes_rd=1.
REQ-020 SHALL clear pending[wb_rd] on wb_valid at the next edge.
REQ-021 SHALL resolve a same-cycle set and clear of the same register with the set winning.

Reset
REQ-022 SHALL, on reset_n=0, immediately clear out_valid and all pending bits to 0 and set all decoded outputs to 0.
REQ-023 SHALL drop an instruction in flight at reset with no partial output.
REQ-024 SHALL hold in_ready=0 while reset_n=0.

Configuration
REQ-025 SHALL, with DECODER_SCOREBOARD_EN defined, include the hazard logic of REQ-018..REQ-021.
REQ-026 SHALL, with DECODER_SCOREBOARD_EN undefined, tie stall to 0, omit the pending register, and ignore wb_valid/wb_rd.

Structure
REQ-027 SHALL take the field bit positions, the TypeCode class constants and the decoded-instruction struct typedef from shared package arm_pkg.
REQ-028 SHALL implement the pending mask and stall logic as sub-module dec_scoreboard, instantiated under DECODER_SCOREBOARD_EN.

Verification
REQ-029 SHALL cover: instr=32'h1263FFFF accepted -> next cycle OpCode=4, TypeCode=0, is_immediate=1, rd=3, rh=1, immediate_value=32'hFFFFFFFF, writes_rd=1.
REQ-030 SHALL cover: out_ready=0 for 3 cycles with in_valid=1 -> outputs held, in_ready=0, and no second instruction lost after out_ready rises.
REQ-031 SHALL cover: writer of r3, then a reader with rh=3 -> stall=1 and in_ready=0 until wb_valid with wb_rd=3, with acceptance exactly one cycle after the writeback edge.
REQ-032 SHALL cover: wb_valid with wb_rd=5 on the same cycle as acceptance of a writer of r5 -> pending[5]=1 afterwards.
REQ-033 SHALL cover: TypeCode=3, OpCode=F -> illegal=1, writes_rd=0, no pending bit set; flush while out_valid=1 -> out_valid=0 next cycle.
REQ-034 SHALL cover: reset_n pulsed low mid-stall -> out_valid=0, pending=0, and in_ready=1 on the first cycle after release.
